// File: rtl/led_bank_pkg.sv
// Shared constants for the LED bank: register addresses, mode encodings and
// the per-mode gate selection helper.
package led_bank_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MODE = 2'd1;
    localparam logic [1:0] ADDR_DIV  = 2'd2;
    localparam logic [1:0] ADDR_DUTY = 2'd3;

    localparam logic [1:0] MODE_STATIC   = 2'b00;
    localparam logic [1:0] MODE_BLINK    = 2'b01;
    localparam logic [1:0] MODE_PWM      = 2'b10;
    localparam logic [1:0] MODE_BLINKPWM = 2'b11;

    // Combine the blink phase and PWM window into a single enable according to mode.
    function automatic logic mode_gate(input logic [1:0] mode,
                                       input logic       phase,
                                       input logic       pwm_on);
        logic g;
        case (mode)
            MODE_STATIC:   g = 1'b1;
            MODE_BLINK:    g = phase;
            MODE_PWM:      g = pwm_on;
            MODE_BLINKPWM: g = phase & pwm_on;
            default:       g = 1'b0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/led_blink_gen.sv
// Blink phase generator: a prescaler counts up to div, then wraps and toggles
// the phase. A write to the divider restarts the count with phase high.
module led_blink_gen
    import led_bank_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic             div_wr,
    output logic             phase
);

    logic [DIV_W-1:0] r_presc;
    logic             r_phase;

    // Prescaler and phase flop; a divider write wins over a terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= {DIV_W{1'b0}};
            r_phase <= 1'b1;
        end else if (div_wr) begin
            r_presc <= {DIV_W{1'b0}};
            r_phase <= 1'b1;
        end else if (r_presc == div) begin
            r_presc <= {DIV_W{1'b0}};
            r_phase <= ~r_phase;
        end else begin
            r_presc <= r_presc + {{(DIV_W-1){1'b0}}, 1'b1};
            r_phase <= r_phase;
        end
    end

    assign phase = r_phase;

endmodule

// File: rtl/led_bank.sv
// Memory-mapped LED controller: latched pattern driven static, blinking,
// PWM-dimmed or blinking+dimmed, with a registered pin output.
module led_bank
    import led_bank_pkg::*;
#(
    parameter int               NUM_LEDS  = 8,
    parameter int               DIV_W     = 24,
    parameter int               PWM_W     = 8,
    parameter logic [DIV_W-1:0] DIV_RESET = 24'd12_499_999
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                we,
    input  logic [1:0]          addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [NUM_LEDS-1:0] led_out
);

    logic [NUM_LEDS-1:0] r_data;
    logic [1:0]          r_mode;
    logic [DIV_W-1:0]    r_div;
    logic [PWM_W-1:0]    r_duty;
    logic [PWM_W-1:0]    r_pwm_cnt;
    logic [NUM_LEDS-1:0] r_led;

    logic                w_wr;
    logic                w_div_wr;
    logic                w_phase;
    logic                w_pwm_on;
    logic                w_gate;
    logic [31:0]         w_rdata;
    logic                w_unused_wdata;

    assign w_wr           = ena & we;
    assign w_div_wr       = w_wr & (addr == ADDR_DIV);
    assign w_pwm_on       = (r_pwm_cnt < r_duty);
    assign w_gate         = mode_gate(r_mode, w_phase, w_pwm_on);
    // Upper write-data bits beyond each register's width are intentionally ignored.
    assign w_unused_wdata = ^wdata;

    led_blink_gen #(
        .DIV_W (DIV_W)
    ) u_blink (
        .clk    (clk),
        .rst_n  (rst_n),
        .div    (r_div),
        .div_wr (w_div_wr),
        .phase  (w_phase)
    );

    // Register file: bus writes land in the addressed register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= {NUM_LEDS{1'b0}};
            r_mode <= MODE_STATIC;
            r_div  <= DIV_RESET;
            r_duty <= {PWM_W{1'b1}};
        end else if (w_wr) begin
            case (addr)
                ADDR_DATA: r_data <= wdata[NUM_LEDS-1:0];
                ADDR_MODE: r_mode <= wdata[1:0];
                ADDR_DIV:  r_div  <= wdata[DIV_W-1:0];
                ADDR_DUTY: r_duty <= wdata[PWM_W-1:0];
                default:   r_data <= r_data;
            endcase
        end else begin
            r_data <= r_data;
        end
    end

    // Free-running PWM counter, wraps naturally at 2^PWM_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= {PWM_W{1'b0}};
        end else begin
            r_pwm_cnt <= r_pwm_cnt + {{(PWM_W-1){1'b0}}, 1'b1};
        end
    end

    // Output register: pattern masked by the mode gate every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= {NUM_LEDS{1'b0}};
        end else begin
            r_led <= r_data & {NUM_LEDS{w_gate}};
        end
    end

    // Read mux: zero-extended register on a read cycle, zero otherwise.
    always_comb begin
        w_rdata = 32'd0;
        if (ena && !we) begin
            case (addr)
                ADDR_DATA: w_rdata[NUM_LEDS-1:0] = r_data;
                ADDR_MODE: w_rdata[1:0]          = r_mode;
                ADDR_DIV:  w_rdata[DIV_W-1:0]    = r_div;
                ADDR_DUTY: w_rdata[PWM_W-1:0]    = r_duty;
                default:   w_rdata               = 32'd0;
            endcase
        end else begin
            w_rdata = 32'd0;
        end
    end

    assign rdata   = w_rdata;
    assign led_out = r_led;

endmodule

// File: doc/led_bank.md
# led_bank

Memory-mapped, parametrised LED output controller on the CPU data bus, replacing the single-register combinational LED port. It holds a latched LED pattern and drives the pins in static, blink, PWM-dimmed or blink+PWM mode, using an internal prescaler and PWM counter. The bus side supports byte-free 32-bit register writes and read-back. `led_out` is a registered output that feeds the board pins.

## Interface
Parameters:
- `NUM_LEDS`, 8: number of LED channels (1..32).
- `DIV_W`, 24: width of the blink divider register and prescaler.
- `PWM_W`, 8: width of the PWM duty register and counter.
- `DIV_RESET`, 24'd12_499_999: reset value of DIV (1 Hz phase toggle at 25 MHz).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `ena`  in  1: chip select from the bus decoder.
- `we`  in  1: write strobe; a write happens when `ena && we`.
- `addr`  in  2: register index.
- `wdata`  in  32: write data.
- `rdata`  out  32: read data (combinational).
- `led_out`  out  NUM_LEDS: registered LED pin drive, 1 = lit.

## Operation
- Register map (unused bits write-ignored, read 0):
  - 0 `DATA` [NUM_LEDS-1:0]: LED pattern.
  - 1 `MODE` [1:0]: 00 static, 01 blink, 10 pwm, 11 blink+pwm.
  - 2 `DIV` [DIV_W-1:0]: blink half-period minus 1, in clocks.
  - 3 `DUTY` [PWM_W-1:0]: PWM on-count.
- Reset values: DATA=0, MODE=00, DIV=DIV_RESET, DUTY=all-ones, prescaler=0, blink phase=1, PWM counter=0, `led_out`=0.
- Prescaler: increments every cycle. When it equals DIV, it returns to 0 and the blink phase toggles. DIV=0 toggles the phase every cycle.
- Writing DIV clears the prescaler to 0 and sets the phase to 1 in the same edge. Reprogramming DIV therefore never waits out a stale count.
- PWM counter: free-runs 0..2^PWM_W-1 and wraps. pwm_on = (cnt < DUTY). DUTY=0 is always off; all-ones is on for 2^PWM_W-1 of 2^PWM_W cycles.
- Gate per mode: static is 1; blink is phase; pwm is pwm_on; blink+pwm is phase & pwm_on.
- Next `led_out` = DATA & {NUM_LEDS{gate}}, registered every cycle.
- Read: `rdata` = selected register zero-extended when `ena && !we`, else 32'b0.
- Simultaneous events: a write to DIV on the same edge the prescaler hits DIV gives the write priority (prescaler=0, phase=1). A write to DATA or MODE takes effect in the gate computation on the next edge.

## Timing
- Write sampled at edge k → register valid after k → `led_out` reflects it after edge k+1 (latency 2 edges from strobe).
- Blink period is 2·(DIV+1) clocks. Phase changes appear on `led_out` one edge after the toggle.
- `rdata` has zero-cycle latency. A read in the same cycle as a write to the same address is impossible (`we` selects one).
- `rst_n` asserted mid-operation clears all state immediately, without waiting for `clk`. The first edge after deassertion is ordinary operation.

## Structure
- Package `led_bank_pkg`: address constants `ADDR_DATA/MODE/DIV/DUTY`, mode constants `MODE_STATIC/BLINK/PWM/BLINKPWM`.
- Sub-module `led_blink_gen`: parametrised by `DIV_W`. Contains the prescaler and phase flop, with inputs `div`, `div_wr`, and output `phase`.
- The register file, PWM counter and output register stay in the top.

## Test plan
- Reset: hold `rst_n`=0 mid-run → `led_out`=0 and `rdata` readbacks DATA=0, MODE=0, DIV=DIV_RESET, DUTY=8'hFF.
- Static: write DATA=8'hA5 at edge k → `led_out`=8'hA5 after edge k+1. Read addr 0 → 32'h000000A5.
- Blink: DIV=3, MODE=01, DATA=8'hFF → `led_out` alternates 8'hFF and 8'h00 every 4 clocks (period 8). Rewriting DIV=3 mid-low-phase → high again after the next edge.
- PWM: MODE=10, DATA=8'h0F, DUTY=64 → exactly 64 of every 256 cycles show 8'h0F, the rest 0. DUTY=0 → always 0.
- Blink+PWM: DIV=255, DUTY=128, MODE=11 → during phase=1, 50% duty; during phase=0, constantly 0.
- Bus idle: `ena`=0 with `we`=1 and any `wdata` → no register change, `rdata`=0.
